// File: rtl/counter_sweep_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// counter_sweep_ctrl_pkg
//   Shared definitions for the triangular sweep sequencer and its counter:
//   default widths, sequencer state encodings and the command bundle the
//   sequencer hands to the up/down counter each cycle.
// -----------------------------------------------------------------------------
package counter_sweep_ctrl_pkg;

    // Default count/bound width and sweep-count width.
    localparam int SW_WIDTH_DEF = 8;
    localparam int SW_CYC_W_DEF = 4;

    // Sequencer states.
    typedef enum logic [1:0] {
        SW_IDLE = 2'd0,
        SW_UP   = 2'd1,
        SW_DOWN = 2'd2
    } sweep_state_t;

    // Per-cycle command to the counter. A load takes priority over enable.
    typedef struct packed {
        logic ld;   // load ld_val on the next edge
        logic en;   // step by one on the next edge
        logic up;   // step direction: 1 = +1, 0 = -1
    } cnt_cmd_t;

    localparam cnt_cmd_t CNT_CMD_HOLD = '{ld: 1'b0, en: 1'b0, up: 1'b1};

    // True when the sweep that is finishing now is the final one of the run.
    // A programmed count of zero wraps through the full 2**CYC_W range, which
    // falls out naturally from modulo arithmetic on n - 1.
    function automatic logic is_last_sweep(
        input logic [SW_CYC_W_DEF-1:0] sweep_idx,
        input logic [SW_CYC_W_DEF-1:0] n_sweeps
    );
        logic [SW_CYC_W_DEF-1:0] last_idx;
        last_idx = n_sweeps - 1'b1;
        return (sweep_idx == last_idx);
    endfunction

endpackage : counter_sweep_ctrl_pkg

// File: rtl/counter_sweep_ctrl_counter.sv
// -----------------------------------------------------------------------------
// counter8b_updown_ld
//   WIDTH-bit up/down counter with synchronous load and count enable.
//   Asynchronous active-high reset clears the count to zero.
//
// Ports
//   i_clk     in   1      rising-edge clock
//   i_reset   in   1      asynchronous, active-high
//   i_ld      in   1      load i_ld_val on the next edge (priority over i_en)
//   i_ld_val  in   WIDTH  value to load
//   i_en      in   1      step the count on the next edge
//   i_dir     in   1      1 = increment, 0 = decrement
//   o_count   out  WIDTH  registered count
// -----------------------------------------------------------------------------
module counter8b_updown_ld #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_ld,
    input  logic [WIDTH-1:0] i_ld_val,
    input  logic             i_en,
    input  logic             i_dir,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;

    always_comb begin
        w_count_nxt = r_count;
        if (i_ld) begin
            w_count_nxt = i_ld_val;
        end else if (i_en) begin
            if (i_dir) begin
                w_count_nxt = r_count + 1'b1;
            end else begin
                w_count_nxt = r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    assign o_count = r_count;

endmodule : counter8b_updown_ld

// File: rtl/counter_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// counter_sweep_ctrl
//   Sequencer that drives an up/down counter through N triangular sweeps
//   (lo -> hi -> lo) and pulses done when the run completes. Bounds and the
//   sweep count are captured on an accepted start; a start with lo >= hi is
//   rejected with a one-cycle err pulse. abort stops a run with the count
//   frozen where it is.
//
// Ports
//   clk       in   1      rising-edge clock
//   reset     in   1      asynchronous, active-high; clears all state
//   start     in   1      request a run (only looked at while idle)
//   abort     in   1      stop the current run; beats start
//   lo        in   WIDTH  lower bound, captured on accepted start
//   hi        in   WIDTH  upper bound, captured on accepted start
//   n_cycles  in   CYC_W  number of sweeps (0 = 2**CYC_W)
//   count     out  WIDTH  counter value
//   dir       out  1      1 = counting up, 0 = counting down
//   busy      out  1      run in progress
//   done      out  1      one-cycle pulse on normal completion
//   err       out  1      one-cycle pulse on a rejected start
// -----------------------------------------------------------------------------
module counter_sweep_ctrl
    import counter_sweep_ctrl_pkg::*;
#(
    parameter int WIDTH = SW_WIDTH_DEF,
    parameter int CYC_W = SW_CYC_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [CYC_W-1:0] n_cycles,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic             err
);

    // Registered state
    sweep_state_t     r_state;
    logic [WIDTH-1:0] r_lo_l;
    logic [WIDTH-1:0] r_hi_l;
    logic [CYC_W-1:0] r_n_l;
    logic [CYC_W-1:0] r_sweep;
    logic             r_dir;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    // Next-state / command signals
    sweep_state_t     w_state_nxt;
    cnt_cmd_t         w_cmd;
    logic [WIDTH-1:0] w_ld_val;
    logic             w_latch;
    logic [CYC_W-1:0] w_sweep_nxt;
    logic             w_dir_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_err_nxt;
    logic [WIDTH-1:0] w_count;
    logic             w_last;
    logic             w_bounds_ok;

    assign w_bounds_ok = (lo < hi);

    // Final-sweep detection: n - 1 modulo 2**CYC_W, so n == 0 gives
    // 2**CYC_W sweeps.
    generate
        if (CYC_W == SW_CYC_W_DEF) begin : g_last_pkg
            assign w_last = is_last_sweep(r_sweep, r_n_l);
        end else begin : g_last_local
            logic [CYC_W-1:0] w_last_idx;
            assign w_last_idx = r_n_l - 1'b1;
            assign w_last     = (r_sweep == w_last_idx);
        end
    endgenerate

    // Next-state and counter command
    always_comb begin
        w_state_nxt = r_state;
        w_cmd       = CNT_CMD_HOLD;
        w_cmd.up    = r_dir;
        w_ld_val    = r_lo_l;
        w_latch     = 1'b0;
        w_sweep_nxt = r_sweep;
        w_dir_nxt   = r_dir;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;

        if (abort) begin
            // Count and dir are left untouched; in IDLE this also swallows
            // a coincident start without flagging err.
            w_state_nxt = SW_IDLE;
            w_busy_nxt  = 1'b0;
        end else begin
            unique case (r_state)
                SW_IDLE: begin
                    if (start) begin
                        if (w_bounds_ok) begin
                            w_latch     = 1'b1;
                            w_cmd.ld    = 1'b1;
                            w_ld_val    = lo;
                            w_dir_nxt   = 1'b1;
                            w_busy_nxt  = 1'b1;
                            w_sweep_nxt = '0;
                            w_state_nxt = SW_UP;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end
                end

                SW_UP: begin
                    if (w_count != r_hi_l) begin
                        w_cmd.en = 1'b1;
                        w_cmd.up = 1'b1;
                    end else begin
                        // Turn around without dwelling on hi.
                        w_cmd.ld    = 1'b1;
                        w_ld_val    = r_hi_l - 1'b1;
                        w_dir_nxt   = 1'b0;
                        w_state_nxt = SW_DOWN;
                    end
                end

                SW_DOWN: begin
                    if (w_count != r_lo_l) begin
                        w_cmd.en = 1'b1;
                        w_cmd.up = 1'b0;
                    end else begin
                        w_sweep_nxt = r_sweep + 1'b1;
                        if (w_last) begin
                            w_busy_nxt  = 1'b0;
                            w_done_nxt  = 1'b1;
                            w_state_nxt = SW_IDLE;
                        end else begin
                            w_cmd.ld    = 1'b1;
                            w_ld_val    = r_lo_l + 1'b1;
                            w_dir_nxt   = 1'b1;
                            w_state_nxt = SW_UP;
                        end
                    end
                end

                default: begin
                    w_state_nxt = SW_IDLE;
                    w_busy_nxt  = 1'b0;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= SW_IDLE;
            r_lo_l  <= '0;
            r_hi_l  <= '0;
            r_n_l   <= '0;
            r_sweep <= '0;
            r_dir   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sweep <= w_sweep_nxt;
            r_dir   <= w_dir_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            if (w_latch) begin
                r_lo_l <= lo;
                r_hi_l <= hi;
                r_n_l  <= n_cycles;
            end
        end
    end

    counter8b_updown_ld #(
        .WIDTH (WIDTH)
    ) u_counter (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_ld     (w_cmd.ld),
        .i_ld_val (w_ld_val),
        .i_en     (w_cmd.en),
        .i_dir    (w_cmd.up),
        .o_count  (w_count)
    );

    assign count = w_count;
    assign dir   = r_dir;
    assign busy  = r_busy;
    assign done  = r_done;
    assign err   = r_err;

endmodule : counter_sweep_ctrl

// File: tb/tb_counter_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_counter_sweep_ctrl
//   Directed bench for counter_sweep_ctrl. Inputs change on the falling edge,
//   outputs are sampled on the falling edge after each rising edge.
// -----------------------------------------------------------------------------
module tb_counter_sweep_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic [7:0] lo;
    logic [7:0] hi;
    logic [3:0] n_cycles;
    logic [7:0] count;
    logic       dir;
    logic       busy;
    logic       done;
    logic       err;

    int checks   = 0;
    int failures = 0;

    counter_sweep_ctrl #(
        .WIDTH (8),
        .CYC_W (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .lo       (lo),
        .hi       (hi),
        .n_cycles (n_cycles),
        .count    (count),
        .dir      (dir),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    int exp1_cnt [13] = '{3, 4, 5, 6, 5, 4, 3, 4, 5, 6, 5, 4, 3};
    int exp1_dir [13] = '{1, 1, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0};
    int exp4_tail [4] = '{2, 3, 2, 1};

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        lo       = 8'd0;
        hi       = 8'd0;
        n_cycles = 4'd0;

        // Reset values
        #1;
        chk("rst_count", count, 0);
        chk("rst_dir",   dir,   1);
        chk("rst_busy",  busy,  0);
        chk("rst_done",  done,  0);
        chk("rst_err",   err,   0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        step();
        chk("idle_count", count, 0);
        chk("idle_busy",  busy,  0);

        // Test 1: lo=3 hi=6 n=2, with a start and bound changes while busy
        lo = 8'd3; hi = 8'd6; n_cycles = 4'd2; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 13; i++) begin
            if (i > 0) step();
            chk("t1_count", count, exp1_cnt[i]);
            chk("t1_dir",   dir,   exp1_dir[i]);
            chk("t1_busy",  busy,  1);
            chk("t1_done",  done,  0);
            chk("t1_err",   err,   0);
            if (i == 4) begin
                start = 1'b1; lo = 8'd0; hi = 8'd100; n_cycles = 4'd1;
            end
            if (i == 6) start = 1'b0;
        end
        step();
        chk("t1_end_done",  done,  1);
        chk("t1_end_busy",  busy,  0);
        chk("t1_end_count", count, 3);
        step();
        chk("t1_post_done",  done,  0);
        chk("t1_post_count", count, 3);
        chk("t1_post_busy",  busy,  0);

        // Test 2: rejected starts
        lo = 8'd6; hi = 8'd6; start = 1'b1;
        step();
        start = 1'b0;
        chk("t2a_err",   err,   1);
        chk("t2a_busy",  busy,  0);
        chk("t2a_count", count, 3);
        step();
        chk("t2a_err_clr", err, 0);
        lo = 8'd9; hi = 8'd2; start = 1'b1;
        step();
        start = 1'b0;
        chk("t2b_err",   err,   1);
        chk("t2b_busy",  busy,  0);
        chk("t2b_count", count, 3);
        step();
        chk("t2b_err_clr", err, 0);

        // Test 3: full range 0..255, one sweep
        lo = 8'd0; hi = 8'd255; n_cycles = 4'd1; start = 1'b1;
        step();
        start = 1'b0;
        chk("t3_first", count, 0);
        chk("t3_busy",  busy,  1);
        for (int k = 1; k <= 510; k++) begin
            step();
            chk("t3_count", count, (k <= 255) ? k : (510 - k));
            chk("t3_dir",   dir,   (k <= 255) ? 1 : 0);
            chk("t3_done",  done,  0);
        end
        step();
        chk("t3_end_done",  done,  1);
        chk("t3_end_busy",  busy,  0);
        chk("t3_end_count", count, 0);

        // Test 4: abort on the way down, then abort+start in idle, then restart
        lo = 8'd10; hi = 8'd20; n_cycles = 4'd3; start = 1'b1;
        step();
        start = 1'b0;
        chk("t4_first", count, 10);
        for (int k = 1; k <= 15; k++) begin
            step();
            chk("t4_count", count, (k <= 10) ? (10 + k) : (30 - k));
        end
        chk("t4_at15_dir", dir, 0);
        step();
        chk("t4_at14", count, 14);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t4_ab_busy",  busy,  0);
        chk("t4_ab_count", count, 14);
        chk("t4_ab_done",  done,  0);
        chk("t4_ab_dir",   dir,   0);
        step();
        chk("t4_ab2_count", count, 14);
        chk("t4_ab2_done",  done,  0);
        abort = 1'b1; start = 1'b1; lo = 8'd5; hi = 8'd2;
        step();
        chk("t4_as_err",   err,   0);
        chk("t4_as_busy",  busy,  0);
        chk("t4_as_count", count, 14);
        lo = 8'd1; hi = 8'd3; n_cycles = 4'd1;
        step();
        chk("t4_as2_busy",  busy,  0);
        chk("t4_as2_count", count, 14);
        abort = 1'b0;
        step();
        start = 1'b0;
        chk("t4_rs_busy",  busy,  1);
        chk("t4_rs_count", count, 1);
        chk("t4_rs_dir",   dir,   1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t4_rs_seq", count, exp4_tail[i]);
        end
        step();
        chk("t4_rs_done", done, 1);
        chk("t4_rs_end",  count, 1);

        // Test 5a: n_cycles=0 runs 16 sweeps
        lo = 8'd3; hi = 8'd5; n_cycles = 4'd0; start = 1'b1;
        step();
        start = 1'b0;
        chk("t5_first", count, 3);
        for (int s = 0; s < 16; s++) begin
            for (int v = 4; v <= 5; v++) begin
                step();
                chk("t5_up", count, v);
                chk("t5_busy", busy, 1);
            end
            for (int v = 4; v >= 3; v--) begin
                step();
                chk("t5_dn", count, v);
                chk("t5_done", done, 0);
            end
        end
        step();
        chk("t5_end_done", done, 1);
        chk("t5_end_busy", busy, 0);
        chk("t5_end_count", count, 3);

        // Test 5b: asynchronous reset mid-run
        lo = 8'd3; hi = 8'd6; n_cycles = 4'd2; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("t5r_pre_count", count, 5);
        #2;
        reset = 1'b1;
        #1;
        chk("t5r_count", count, 0);
        chk("t5r_dir",   dir,   1);
        chk("t5r_busy",  busy,  0);
        step();
        chk("t5r_hold_count", count, 0);
        chk("t5r_hold_done",  done,  0);
        reset = 1'b0;
        step();
        chk("t5r_after_done",  done,  0);
        chk("t5r_after_busy",  busy,  0);
        chk("t5r_after_count", count, 0);
        lo = 8'd2; hi = 8'd3; n_cycles = 4'd1; start = 1'b1;
        step();
        start = 1'b0;
        chk("t5r_new_busy",  busy,  1);
        chk("t5r_new_count", count, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_counter_sweep_ctrl
